// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: captures operands on a start handshake, then
// ripples one bit per clock through a single full_adder cell, LSB first.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Start_valid,
    output logic             Start_ready,
    input  logic [WIDTH-1:0] Operand_A,
    input  logic [WIDTH-1:0] Operand_B,
    input  logic             Carry_in,
    output logic [WIDTH-1:0] Sum_out,
    output logic             Carry_out,
    output logic             Overflow,
    output logic             Result_valid,
    input  logic             Result_ready,
    output logic             Busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;
    logic             r_ovf;
    logic             w_start;
    logic             w_last;
    logic             w_fa_sum;
    logic             w_fa_cout;

    assign w_start = (r_state == IDLE) && Start_valid;
    assign w_last  = (r_state == SHIFT) && (r_cnt == LAST_BIT);

    // The one-bit cell that does all the arithmetic.
    full_adder u_fa (
        .i_a (r_a_sh[0]),
        .i_b (r_b_sh[0]),
        .i_c (r_carry),
        .o_s (w_fa_sum),
        .o_c (w_fa_cout)
    );

    // State register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (Start_valid)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last)       w_state_nxt = DONE;
            DONE:    if (Result_ready) w_state_nxt = IDLE;
            default:                   w_state_nxt = IDLE;
        endcase
    end

    // Operand capture, per-bit shift and result/carry/overflow registers.
    // The result register doubles as Sum_out and keeps its value until the
    // next start clears it; carry_q doubles as Carry_out likewise.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_start) begin
            r_a_sh  <= Operand_A;
            r_b_sh  <= Operand_B;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= Carry_in;
        end else if (r_state == SHIFT) begin
            r_a_sh  <= r_a_sh >> 1;
            r_b_sh  <= r_b_sh >> 1;
            r_res   <= {w_fa_sum, r_res[WIDTH-1:1]};
            r_carry <= w_fa_cout;
            // Counter parks on the last index instead of wrapping.
            if (w_last) begin
                r_ovf <= r_carry ^ w_fa_cout;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    assign Start_ready  = (r_state == IDLE);
    assign Busy         = (r_state == SHIFT);
    assign Result_valid = (r_state == DONE);
    assign Sum_out      = r_res;
    assign Carry_out    = r_carry;
    assign Overflow     = r_ovf;

endmodule

// One-bit full adder cell.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    assign o_s = i_a ^ i_b ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & (i_a ^ i_b));

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder with a queue-based scoreboard.
module tb_serial_adder;

    localparam int unsigned W = 8;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    logic         Clk;
    logic         Reset_n;
    logic         Start_valid;
    logic         Start_ready;
    logic [W-1:0] Operand_A;
    logic [W-1:0] Operand_B;
    logic         Carry_in;
    logic [W-1:0] Sum_out;
    logic         Carry_out;
    logic         Overflow;
    logic         Result_valid;
    logic         Result_ready;
    logic         Busy;

    int   total;
    int   bad;
    int   cyc;
    res_t sb_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .Clk          (Clk),
        .Reset_n      (Reset_n),
        .Start_valid  (Start_valid),
        .Start_ready  (Start_ready),
        .Operand_A    (Operand_A),
        .Operand_B    (Operand_B),
        .Carry_in     (Carry_in),
        .Sum_out      (Sum_out),
        .Carry_out    (Carry_out),
        .Overflow     (Overflow),
        .Result_valid (Result_valid),
        .Result_ready (Result_ready),
        .Busy         (Busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference: full-width add, overflow from operand/result sign bits.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
        logic [W:0] full;
        res_t r;
        full   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
        r.sum  = full[W-1:0];
        r.cout = full[W];
        r.ovf  = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
        cyc++;
    endtask

    // Present one operation for a single handshake edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input bit push);
        chk("start_ready_before_start", 32'(Start_ready), 32'd1);
        Operand_A   = a;
        Operand_B   = b;
        Carry_in    = cin;
        Start_valid = 1'b1;
        tick();
        Start_valid = 1'b0;
        if (push) sb_q.push_back(model(a, b, cin));
    endtask

    // Wait (bounded) for Result_valid, check latency/busy time and the result.
    task automatic get_result(input string tag);
        int   n;
        int   nbusy;
        res_t e;
        n     = 0;
        nbusy = 0;
        while (!Result_valid && n < 40) begin
            if (Busy) nbusy++;
            tick();
            n++;
        end
        chk({tag, "_latency"}, 32'(n), 32'(W));
        chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(W));
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() != 0), 32'd1);
        if (Result_valid && sb_q.size() != 0) begin
            e = sb_q.pop_front();
            chk({tag, "_sum"},  32'(Sum_out),   32'(e.sum));
            chk({tag, "_cout"}, 32'(Carry_out), 32'(e.cout));
            chk({tag, "_ovf"},  32'(Overflow),  32'(e.ovf));
        end
    endtask

    // Accept the result and confirm the return to IDLE with outputs held.
    task automatic consume(input string tag);
        logic [W-1:0] s;
        logic         c;
        logic         o;
        s = Sum_out;
        c = Carry_out;
        o = Overflow;
        Result_ready = 1'b1;
        tick();
        Result_ready = 1'b0;
        chk({tag, "_valid_fall"}, 32'(Result_valid), 32'd0);
        chk({tag, "_ready_back"}, 32'(Start_ready), 32'd1);
        chk({tag, "_sum_hold"},   32'(Sum_out), 32'(s));
        chk({tag, "_cout_hold"},  32'(Carry_out), 32'(c));
        chk({tag, "_ovf_hold"},   32'(Overflow), 32'(o));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout observed=hang expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] hs;
        logic         hc;
        logic         ho;
        int           n;
        int           prev_hs;
        int           nv;
        int           nb;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;

        total        = 0;
        bad          = 0;
        cyc          = 0;
        Reset_n      = 1'b0;
        Start_valid  = 1'b0;
        Operand_A    = '0;
        Operand_B    = '0;
        Carry_in     = 1'b0;
        Result_ready = 1'b0;

        // Reset values.
        #12;
        chk("rst_sum",   32'(Sum_out), 32'd0);
        chk("rst_cout",  32'(Carry_out), 32'd0);
        chk("rst_ovf",   32'(Overflow), 32'd0);
        chk("rst_valid", 32'(Result_valid), 32'd0);
        chk("rst_busy",  32'(Busy), 32'd0);
        chk("rst_ready", 32'(Start_ready), 32'd1);
        Reset_n = 1'b1;
        tick();

        // Basic additions.
        start_op(8'h5A, 8'h33, 1'b0, 1'b1);
        get_result("add_5a_33");
        consume("add_5a_33");
        start_op(8'hFF, 8'h01, 1'b0, 1'b1);
        get_result("add_ff_01");
        consume("add_ff_01");
        start_op(8'hFF, 8'hFF, 1'b1, 1'b1);
        get_result("add_ff_ff_c");
        consume("add_ff_ff_c");

        // Backpressure in DONE with ignored start pulses.
        start_op(8'h70, 8'h10, 1'b0, 1'b1);
        get_result("bp");
        hs = Sum_out;
        hc = Carry_out;
        ho = Overflow;
        for (int i = 0; i < 5; i++) begin
            Operand_A   = 8'(8'h11 * (i + 1));
            Operand_B   = 8'(8'h22 + i);
            Start_valid = (i % 2 == 0);
            tick();
            chk("bp_valid_hold", 32'(Result_valid), 32'd1);
            chk("bp_ready_low",  32'(Start_ready), 32'd0);
            chk("bp_sum_hold",   32'(Sum_out), 32'(hs));
            chk("bp_cout_hold",  32'(Carry_out), 32'(hc));
            chk("bp_ovf_hold",   32'(Overflow), 32'(ho));
        end
        Start_valid = 1'b0;
        consume("bp");
        tick();
        chk("bp_no_capture_busy", 32'(Busy), 32'd0);

        // Reset in the middle of SHIFT aborts the operation.
        start_op(8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        tick();
        tick();
        chk("rst_mid_busy_before", 32'(Busy), 32'd1);
        Reset_n = 1'b0;
        #2;
        chk("rstm_sum",   32'(Sum_out), 32'd0);
        chk("rstm_cout",  32'(Carry_out), 32'd0);
        chk("rstm_ovf",   32'(Overflow), 32'd0);
        chk("rstm_valid", 32'(Result_valid), 32'd0);
        chk("rstm_busy",  32'(Busy), 32'd0);
        chk("rstm_ready", 32'(Start_ready), 32'd1);
        Reset_n = 1'b1;
        tick();
        nv = 0;
        nb = 0;
        for (int i = 0; i < 12; i++) begin
            if (Result_valid) nv++;
            if (Busy) nb++;
            tick();
        end
        chk("rstm_no_result", 32'(nv), 32'd0);
        chk("rstm_no_busy",   32'(nb), 32'd0);
        start_op(8'h80, 8'h80, 1'b0, 1'b1);
        get_result("add_80_80");
        consume("add_80_80");

        // Back-to-back with Start_valid and Result_ready tied high.
        Result_ready = 1'b1;
        Start_valid  = 1'b1;
        prev_hs      = -1;
        for (int k = 0; k < 100; k++) begin
            n = 0;
            while (!Start_ready && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_ready_wait", 32'(Start_ready), 32'd1);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            Operand_A = ra;
            Operand_B = rb;
            Carry_in  = rc;
            tick();
            sb_q.push_back(model(ra, rb, rc));
            if (prev_hs >= 0) chk("b2b_interval", 32'(cyc - prev_hs), 32'(W + 2));
            prev_hs = cyc;
            if (k == 99) Start_valid = 1'b0;
            get_result("b2b");
        end
        tick();
        Result_ready = 1'b0;
        chk("b2b_idle", 32'(Start_ready), 32'd1);

        // Operands changed right after capture have no effect.
        start_op(8'h0F, 8'h01, 1'b0, 1'b1);
        Operand_A = 8'hFF;
        Operand_B = 8'hFF;
        get_result("late_change");
        consume("late_change");

        chk("sb_empty_end", 32'(sb_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
